// File: rtl/taylor_out_frame.sv
// rtl/taylor_out_frame.sv - assembles per-port Taylor results into frames and queues them in a FWFT FIFO
module taylor_out_frame #(
  parameter int               NBITS  = 28,
  parameter int               NPORT  = 4,
  parameter logic [NPORT-1:0] FMASK  = 4'b1111,
  parameter int               FDEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [NBITS-1:0]         io_out,
  input  logic        [NPORT-1:0]         out_en,
  output logic        [NPORT*NBITS-1:0]   frame_data,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic        [$clog2(FDEPTH):0]  level,
  output logic        [NPORT-1:0]         seen,
  output logic                            ovf_err,
  output logic                            dup_err,
  output logic                            hot_err,
  input  logic                            clr_err
);

  localparam int AW = $clog2(FDEPTH);
  localparam int LW = AW + 1;

  logic [NBITS-1:0]       stage [NPORT];
  logic [NPORT*NBITS-1:0] mem   [FDEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  logic                   one_hot;
  logic                   multi_hot;
  logic [NPORT-1:0]       wr_mask;
  logic [NPORT-1:0]       next_seen;
  logic                   complete;
  logic                   dup_hit;
  logic [NPORT*NBITS-1:0] new_frame;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Decode the strobe, evaluate completion and build the outgoing frame with
  // this cycle's word bypassing staging for the completing port.
  always_comb begin
    one_hot   = (out_en != '0) && ((out_en & (out_en - 1'b1)) == '0);
    multi_hot = (out_en != '0) && !one_hot;
    wr_mask   = one_hot ? (out_en & FMASK) : '0;
    next_seen = seen | wr_mask;
    complete  = (wr_mask != '0) && ((next_seen & FMASK) == FMASK);
    dup_hit   = (wr_mask & seen) != '0;
    new_frame = '0;
    for (int k = 0; k < NPORT; k++) begin
      new_frame[k*NBITS +: NBITS] = wr_mask[k] ? io_out : stage[k];
    end
    full = (level == LW'(FDEPTH));
    pop  = frame_valid && frame_ready;
    push = complete && (!full || pop);
    drop = complete && full && !pop;
  end

  assign frame_valid = (level != '0);
  assign frame_data  = frame_valid ? mem[rd_ptr] : '0;

  // Staging words and per-port occupancy; seen clears whenever a frame completes,
  // whether or not the FIFO accepted it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen <= '0;
      for (int k = 0; k < NPORT; k++) stage[k] <= '0;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (wr_mask[k]) stage[k] <= io_out;
      end
      seen <= complete ? '0 : next_seen;
    end
  end

  // Frame storage; the output is gated by frame_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_frame;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since FDEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      dup_err <= 1'b0;
      hot_err <= 1'b0;
    end else begin
      ovf_err <= drop      ? 1'b1 : (clr_err ? 1'b0 : ovf_err);
      dup_err <= dup_hit   ? 1'b1 : (clr_err ? 1'b0 : dup_err);
      hot_err <= multi_hot ? 1'b1 : (clr_err ? 1'b0 : hot_err);
    end
  end

endmodule

// File: tb/tb_taylor_out_frame.sv
// tb/tb_taylor_out_frame.sv - scoreboard bench for taylor_out_frame
module tb_taylor_out_frame;
  localparam int NB = 28;
  localparam int NP = 4;
  localparam int FW = NB * NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] io_out = '0;
  logic [NP-1:0] out_en = '0;
  logic [NP-1:0] out_en2 = '0;
  logic          frame_ready = 1'b0;
  logic          frame_ready2 = 1'b0;
  logic          clr_err = 1'b0;

  logic [FW-1:0] frame_data, frame_data2;
  logic          frame_valid, frame_valid2;
  logic [2:0]    level, level2;
  logic [NP-1:0] seen, seen2;
  logic          ovf_err, dup_err, hot_err;
  logic          ovf_err2, dup_err2, hot_err2;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_exp;

  taylor_out_frame dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .level(level), .seen(seen), .ovf_err(ovf_err), .dup_err(dup_err),
    .hot_err(hot_err), .clr_err(clr_err)
  );

  taylor_out_frame #(.FMASK(4'b0011)) dut2 (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en2),
    .frame_data(frame_data2), .frame_valid(frame_valid2), .frame_ready(frame_ready2),
    .level(level2), .seen(seen2), .ovf_err(ovf_err2), .dup_err(dup_err2),
    .hot_err(hot_err2), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] pack4(input logic [NB-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic cyc(input logic [NP-1:0] en, input logic [NB-1:0] d);
    out_en = en;
    io_out = d;
    @(posedge clk); #1;
    out_en = '0;
  endtask

  task automatic full_frame(input int f);
    for (int k = 0; k < NP; k++) cyc(NP'(1 << k), NB'(f * 16 + k));
  endtask

  // Scoreboard: every accepted pop must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && frame_valid && frame_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h expected=none", frame_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (frame_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data got=%h expected=%h", frame_data, mon_exp);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d expected=0", level); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", frame_valid); end
    checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data got=%h expected=0", frame_data); end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL reset_seen got=%b expected=0000", seen); end
    checks++; if ({ovf_err, dup_err, hot_err} !== 3'b000) begin errors++; $display("FAIL reset_errs got=%b expected=000", {ovf_err, dup_err, hot_err}); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [NB-1:0] w [NP];
    w[0] = 28'd100; w[1] = 28'(-5); w[2] = 28'h7FFFFFF; w[3] = 28'h8000000;
    frame_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc(NP'(1 << k), w[k]);
    checks++; if (seen !== 4'b0111 || frame_valid !== 1'b0) begin errors++; $display("FAIL single_partial got seen=%b valid=%b expected seen=0111 valid=0", seen, frame_valid); end
    exp_q.push_back(pack4(w[0], w[1], w[2], w[3]));
    cyc(4'b1000, w[3]);
    checks++; if (frame_valid !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL single_valid got valid=%b level=%0d expected valid=1 level=1", frame_valid, level); end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL single_seen got=%b expected=0000", seen); end
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (frame_data[k*NB +: NB] !== w[k]) begin errors++; $display("FAIL single_slice%0d got=%h expected=%h", k, frame_data[k*NB +: NB], w[k]); end
    end
    frame_ready = 1'b1; @(posedge clk); #1; frame_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_drain got=%0d expected=0", level); end
  endtask

  task automatic test_dup;
    cyc(4'b0100, 28'd7);
    cyc(4'b0001, 28'hA);
    cyc(4'b0100, 28'd9);
    checks++; if (dup_err !== 1'b1 || seen !== 4'b0101) begin errors++; $display("FAIL dup_flag got dup=%b seen=%b expected dup=1 seen=0101", dup_err, seen); end
    cyc(4'b1000, 28'hB);
    exp_q.push_back(pack4(28'hA, 28'hC, 28'd9, 28'hB));
    cyc(4'b0010, 28'hC);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL dup_level got=%0d expected=1", level); end
    clr_err = 1'b1; cyc(4'b0000, 28'd0); clr_err = 1'b0;
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_clear got=%b expected=0", dup_err); end
    frame_ready = 1'b1; @(posedge clk); #1; frame_ready = 1'b0;
  endtask

  task automatic test_overflow;
    for (int f = 1; f <= 5; f++) begin
      if (f <= 4) exp_q.push_back(pack4(NB'(f*16), NB'(f*16+1), NB'(f*16+2), NB'(f*16+3)));
      full_frame(f);
    end
    checks++; if (level !== 3'd4 || ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_state got level=%0d ovf=%b expected level=4 ovf=1", level, ovf_err); end
    checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL ovf_seen got=%b expected=0000", seen); end
    frame_ready = 1'b1; repeat (4) @(posedge clk); #1; frame_ready = 1'b0;
    checks++; if (level !== 3'd0 || frame_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got level=%0d valid=%b expected 0 0", level, frame_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_order got pending=%0d expected=0", exp_q.size()); end
    clr_err = 1'b1; cyc(4'b0000, 28'd0); clr_err = 1'b0;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b expected=0", ovf_err); end
  endtask

  task automatic test_full_pop;
    for (int f = 6; f <= 9; f++) begin
      exp_q.push_back(pack4(NB'(f*16), NB'(f*16+1), NB'(f*16+2), NB'(f*16+3)));
      full_frame(f);
    end
    for (int k = 0; k < 3; k++) cyc(NP'(1 << k), NB'(160 + k));
    exp_q.push_back(pack4(NB'(160), NB'(161), NB'(162), NB'(163)));
    frame_ready = 1'b1;
    cyc(4'b1000, NB'(163));
    checks++; if (level !== 3'd4 || ovf_err !== 1'b0) begin errors++; $display("FAIL fullpop_state got level=%0d ovf=%b expected level=4 ovf=0", level, ovf_err); end
    repeat (4) @(posedge clk); #1; frame_ready = 1'b0;
    checks++; if (level !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL fullpop_drain got level=%0d pending=%0d expected 0 0", level, exp_q.size()); end
  endtask

  task automatic test_hot;
    cyc(4'b0001, 28'h111);
    cyc(4'b0110, 28'h222);
    checks++; if (seen !== 4'b0001 || hot_err !== 1'b1) begin errors++; $display("FAIL hot_flag got seen=%b hot=%b expected seen=0001 hot=1", seen, hot_err); end
    clr_err = 1'b1; cyc(4'b0011, 28'h333); clr_err = 1'b0;
    checks++; if (hot_err !== 1'b1 || seen !== 4'b0001) begin errors++; $display("FAIL hot_clr_race got hot=%b seen=%b expected hot=1 seen=0001", hot_err, seen); end
    clr_err = 1'b1; cyc(4'b0000, 28'd0); clr_err = 1'b0;
    checks++; if (hot_err !== 1'b0) begin errors++; $display("FAIL hot_clear got=%b expected=0", hot_err); end
    cyc(4'b0010, 28'h444);
    cyc(4'b0100, 28'h555);
    exp_q.push_back(pack4(28'h111, 28'h444, 28'h555, 28'h666));
    cyc(4'b1000, 28'h666);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL hot_level got=%0d expected=1", level); end
    frame_ready = 1'b1; @(posedge clk); #1; frame_ready = 1'b0;
  endtask

  task automatic test_mask;
    out_en2 = 4'b1000; io_out = 28'h999; @(posedge clk); #1; out_en2 = '0;
    checks++; if (seen2 !== 4'b0000 || frame_valid2 !== 1'b0 || hot_err2 !== 1'b0) begin errors++; $display("FAIL mask_ignore got seen=%b valid=%b hot=%b expected 0000 0 0", seen2, frame_valid2, hot_err2); end
    out_en2 = 4'b0001; io_out = 28'h0AB; @(posedge clk); #1; out_en2 = '0;
    checks++; if (seen2 !== 4'b0001) begin errors++; $display("FAIL mask_seen got=%b expected=0001", seen2); end
    out_en2 = 4'b0010; io_out = 28'h0CD; @(posedge clk); #1; out_en2 = '0;
    checks++; if (frame_valid2 !== 1'b1 || level2 !== 3'd1 || seen2 !== 4'b0000) begin errors++; $display("FAIL mask_done got valid=%b level=%0d seen=%b expected 1 1 0000", frame_valid2, level2, seen2); end
    checks++; if (frame_data2 !== pack4(28'h0AB, 28'h0CD, 28'h0, 28'h0)) begin errors++; $display("FAIL mask_data got=%h expected=%h", frame_data2, pack4(28'h0AB, 28'h0CD, 28'h0, 28'h0)); end
  endtask

  task automatic test_reset_async;
    for (int f = 11; f <= 12; f++) begin
      exp_q.push_back(pack4(NB'(f*16), NB'(f*16+1), NB'(f*16+2), NB'(f*16+3)));
      full_frame(f);
    end
    cyc(4'b0001, 28'h1);
    cyc(4'b0100, 28'h3);
    checks++; if (seen !== 4'b0101 || level !== 3'd2) begin errors++; $display("FAIL areset_pre got seen=%b level=%0d expected 0101 2", seen, level); end
    #3; rst = 1'b1; #1;
    exp_q.delete();
    checks++; if (seen !== 4'b0000 || level !== 3'd0 || frame_valid !== 1'b0 || frame_data !== '0) begin errors++; $display("FAIL areset_now got seen=%b level=%0d valid=%b data=%h expected all 0", seen, level, frame_valid, frame_data); end
    @(posedge clk); #1; rst = 1'b0;
    exp_q.push_back(pack4(NB'(208), NB'(209), NB'(210), NB'(211)));
    full_frame(13);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL areset_after got=%0d expected=1", level); end
    frame_ready = 1'b1; @(posedge clk); #1; frame_ready = 1'b0;
    checks++; if (level !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL areset_drain got level=%0d pending=%0d expected 0 0", level, exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_dup;
    test_overflow;
    test_full_pop;
    test_hot;
    test_mask;
    test_reset_async;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending got=%0d expected=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/taylor_out_frame.md
Name: taylor_out_frame

Overview:
- Downstream stage of the floating-point Taylor-network processor wrapper.
- Consumes the integer result bus (io_out) and the one-hot port strobes (out_en) that the output address decoder produces.
- Assembles the per-port results into one wide frame and queues completed frames in a small FIFO.
- Presents frames to the consumer over a valid/ready handshake.

Parameters:
NBITS, 28, width of one result word (matches io_out width)
NPORT, 4, number of processor output ports (width of out_en)
FMASK, 4'b1111, ports that must be written before a frame is complete; bit k = port k
FDEPTH, 4, frame FIFO depth in frames; power of 2, >= 2

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
io_out  in  NBITS  signed result word, valid in the cycle its out_en bit is high
out_en  in  NPORT  one-cycle write strobe per port, expected one-hot
frame_data  out  NPORT*NBITS  FIFO head frame; port k occupies bits [k*NBITS +: NBITS]
frame_valid  out  1  FIFO non-empty
frame_ready  in  1  consumer accepts the head frame when frame_valid && frame_ready
level  out  $clog2(FDEPTH)+1  frames currently queued
seen  out  NPORT  staging occupancy, bit k = port k captured for the current frame
ovf_err  out  1  sticky: a completed frame was dropped because the FIFO was full
dup_err  out  1  sticky: a port was rewritten before its frame completed
hot_err  out  1  sticky: out_en had more than one bit set
clr_err  in  1  synchronous clear of all three sticky flags

Behaviour:
- Reset values while rst is high:
  - seen = 0; staging registers = 0; FIFO pointers = 0.
  - level = 0; frame_valid = 0; frame_data = 0.
  - all error flags = 0.
  - Reset mid-frame discards partial staging and all queued frames.
- Capture:
  - out_en one-hot with bit k set in FMASK → staging[k] <= io_out and seen[k] <= 1.
  - out_en one-hot with bit k not in FMASK → ignored; no error.
  - out_en == 0 → no action.
- Multi-hot out_en → nothing captured; hot_err <= 1.
- Duplicate write: seen[k] already 1 and port k written again → staging[k] overwritten, dup_err <= 1, frame still incomplete.
- Completion is evaluated combinationally, with next_seen = seen | this cycle's write.
  - When (next_seen & FMASK) == FMASK, the frame is pushed in the same edge, using this cycle's io_out for the completing port.
  - seen is cleared to 0 on that edge.
  - Latency: completing strobe at edge N → frame_valid high after edge N when the FIFO was empty; frame_data equals the frame from edge N.
- FIFO behaviour:
  - First-word-fall-through: frame_data always shows the head entry.
  - Pop when frame_valid && frame_ready.
  - Push while full with no pop in the same cycle → frame dropped, ovf_err <= 1, seen still cleared.
  - Push and pop in the same cycle while full → both accepted; level unchanged.
  - Push and pop in the same cycle while empty → push only; the pop is impossible because frame_valid = 0.
  - Pointers wrap modulo FDEPTH; level in range 0..FDEPTH.
- frame_ready while frame_valid = 0 has no effect.
- clr_err clears the sticky flags; a new error event in the same cycle wins (flag is set).
- Staging registers keep their last values after a push; only seen is cleared.
- No arithmetic on the data; words are passed through bit-exact, sign preserved.

Test Plan:
- Single frame: strobe ports 0..3 with io_out = 100, -5, 0x7FFFFFF, -0x8000000, frame_ready = 0 → after the 4th edge, frame_valid = 1, level = 1, seen = 0, and each frame_data slice matches its word exactly.
- Out-of-order and duplicate: write ports 2, 0, 2 (values 7 then 9), 3, 1 → one frame with port2 = 9, dup_err = 1; clr_err → dup_err = 0.
- Overflow:
  - Hold frame_ready = 0 and complete 5 frames at FDEPTH = 4 → level = 4, ovf_err = 1.
  - Then pop 4 → frames 1..4 come out in order; frame 5 is absent.
- Full plus simultaneous pop: with level = 4 and frame_ready = 1, complete a frame in the same cycle → level stays 4, ovf_err stays 0, and the new frame appears last.
- Illegal strobes: out_en = 4'b0110 → seen unchanged, hot_err = 1. FMASK = 4'b0011 with a port-3 strobe → ignored, and the frame completes after ports 0 and 1 only.
- Reset: assert rst asynchronously with seen = 4'b0101 and level = 2 → all outputs 0 immediately. After release, a full 4-port sequence yields exactly one frame.
